// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers one finished result per FU and broadcasts up to N per cycle, round-robin.
// Optional same-cycle bypass of empty buffers is enabled by defining CDB_BYPASS_EN.
module cdb_arbiter #(
    parameter int NUM_REQ    = 8,
    parameter int N          = 3,
    parameter int PHYS_TAG_W = 6,
    parameter int ROB_IDX_W  = 5,
    parameter int DATA_W     = 32
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            mispredict,
    input  logic [NUM_REQ-1:0]              fu_valid,
    input  logic [NUM_REQ*PHYS_TAG_W-1:0]   fu_tag,
    input  logic [NUM_REQ*ROB_IDX_W-1:0]    fu_rob_idx,
    input  logic [NUM_REQ*DATA_W-1:0]       fu_data,
    output logic [NUM_REQ-1:0]              fu_ready,
    output logic [N-1:0]                    cdb_valid,
    output logic [N*PHYS_TAG_W-1:0]         cdb_tag,
    output logic [N*ROB_IDX_W-1:0]          cdb_rob_idx,
    output logic [N*DATA_W-1:0]             cdb_data
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]     buf_valid_r;
    logic [PHYS_TAG_W-1:0]  buf_tag_r  [NUM_REQ];
    logic [ROB_IDX_W-1:0]   buf_rob_r  [NUM_REQ];
    logic [DATA_W-1:0]      buf_data_r [NUM_REQ];
    logic [PTR_W-1:0]       rr_ptr_r;
    logic [PTR_W-1:0]       rr_nxt_s;

    logic [NUM_REQ-1:0]     cand_s;
    logic [NUM_REQ-1:0]     grant_s;
    logic [NUM_REQ-1:0]     bypass_s;
    logic [NUM_REQ-1:0]     xfer_s;
    logic [NUM_REQ-1:0]     fu_ready_s;
    logic                   any_grant_s;
    int                     pos_s      [NUM_REQ];
    int                     rank_s     [NUM_REQ];
    int                     best_pos_s;
    int                     last_s;

    logic [N-1:0]           slot_valid_s;
    logic [PHYS_TAG_W-1:0]  slot_tag_s  [N];
    logic [ROB_IDX_W-1:0]   slot_rob_s  [N];
    logic [DATA_W-1:0]      slot_data_s [N];

    // Candidate set: buffered entries, plus live inputs into empty buffers when bypass is built in
    always_comb begin
        cand_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef CDB_BYPASS_EN
            cand_s[i] = buf_valid_r[i] | fu_valid[i];
`else
            cand_s[i] = buf_valid_r[i];
`endif
        end
    end

    // Scan position of each FU relative to the round-robin pointer
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            pos_s[i] = i - int'(rr_ptr_r);
            if (pos_s[i] < 0) begin
                pos_s[i] = pos_s[i] + NUM_REQ;
            end else begin
                pos_s[i] = pos_s[i];
            end
        end
    end

    // Rank = number of candidates ahead in scan order; the first N candidates win
    always_comb begin
        grant_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rank_s[i] = 0;
            for (int m = 0; m < NUM_REQ; m++) begin
                if (cand_s[m] && (pos_s[m] < pos_s[i])) begin
                    rank_s[i] = rank_s[i] + 1;
                end else begin
                    rank_s[i] = rank_s[i];
                end
            end
            grant_s[i] = cand_s[i] && (rank_s[i] < N);
        end
        any_grant_s = |grant_s;
        bypass_s    = grant_s & ~buf_valid_r;
    end

    // Route each granted FU to the CDB slot matching its rank
    always_comb begin
        slot_valid_s = '0;
        for (int k = 0; k < N; k++) begin
            slot_tag_s[k]  = '0;
            slot_rob_s[k]  = '0;
            slot_data_s[k] = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_s[i] && (rank_s[i] == k)) begin
                    slot_valid_s[k] = 1'b1;
                    if (buf_valid_r[i]) begin
                        slot_tag_s[k]  = buf_tag_r[i];
                        slot_rob_s[k]  = buf_rob_r[i];
                        slot_data_s[k] = buf_data_r[i];
                    end else begin
                        slot_tag_s[k]  = fu_tag[i*PHYS_TAG_W +: PHYS_TAG_W];
                        slot_rob_s[k]  = fu_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
                        slot_data_s[k] = fu_data[i*DATA_W +: DATA_W];
                    end
                end else begin
                    slot_valid_s[k] = slot_valid_s[k];
                end
            end
        end
    end

    // Next pointer: one past the granted FU that came last in scan order
    always_comb begin
        best_pos_s = -1;
        last_s     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s[i] && (pos_s[i] > best_pos_s)) begin
                best_pos_s = pos_s[i];
                last_s     = i;
            end else begin
                best_pos_s = best_pos_s;
            end
        end
        if (last_s == NUM_REQ - 1) begin
            rr_nxt_s = '0;
        end else begin
            rr_nxt_s = PTR_W'(last_s + 1);
        end
    end

    // Ready: free buffer or one being drained this cycle; everything is accepted (and dropped) on flush
    always_comb begin
        if (mispredict) begin
            fu_ready_s = {NUM_REQ{1'b1}};
        end else begin
            fu_ready_s = ~buf_valid_r | grant_s;
        end
        xfer_s = fu_valid & fu_ready_s;
    end

    assign fu_ready = fu_ready_s;

    // Per-FU result buffers; a refill in the same cycle as a grant keeps the entry valid
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buf_valid_r <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                buf_tag_r[i]  <= '0;
                buf_rob_r[i]  <= '0;
                buf_data_r[i] <= '0;
            end
        end else if (mispredict) begin
            buf_valid_r <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (xfer_s[i] && !bypass_s[i]) begin
                    buf_valid_r[i] <= 1'b1;
                    buf_tag_r[i]   <= fu_tag[i*PHYS_TAG_W +: PHYS_TAG_W];
                    buf_rob_r[i]   <= fu_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
                    buf_data_r[i]  <= fu_data[i*DATA_W +: DATA_W];
                end else if (grant_s[i]) begin
                    buf_valid_r[i] <= 1'b0;
                end else begin
                    buf_valid_r[i] <= buf_valid_r[i];
                end
            end
        end
    end

    // Registered CDB broadcast
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cdb_valid   <= '0;
            cdb_tag     <= '0;
            cdb_rob_idx <= '0;
            cdb_data    <= '0;
        end else if (mispredict) begin
            cdb_valid   <= '0;
            cdb_tag     <= '0;
            cdb_rob_idx <= '0;
            cdb_data    <= '0;
        end else begin
            cdb_valid <= slot_valid_s;
            for (int k = 0; k < N; k++) begin
                cdb_tag[k*PHYS_TAG_W +: PHYS_TAG_W]  <= slot_tag_s[k];
                cdb_rob_idx[k*ROB_IDX_W +: ROB_IDX_W] <= slot_rob_s[k];
                cdb_data[k*DATA_W +: DATA_W]          <= slot_data_s[k];
            end
        end
    end

    // Round-robin pointer, held across flushes and idle cycles
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_r <= '0;
        end else if (mispredict) begin
            rr_ptr_r <= rr_ptr_r;
        end else if (any_grant_s) begin
            rr_ptr_r <= rr_nxt_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    cdb_arbiter_checker #(
        .NUM_REQ (NUM_REQ),
        .N       (N),
        .PTR_W   (PTR_W)
    ) u_checker (
        .clock     (clock),
        .reset     (reset),
        .cdb_valid (cdb_valid),
        .rr_ptr    (rr_ptr_r)
    );

endmodule

// Structural invariants of the arbiter outputs: occupied CDB slots form a prefix, pointer stays in range.
module cdb_arbiter_checker #(
    parameter int NUM_REQ = 8,
    parameter int N       = 3,
    parameter int PTR_W   = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     cdb_valid,
    input  logic [PTR_W-1:0] rr_ptr
);

    logic prefix_ok_s;

    // Slot k may only be occupied when slot k-1 is
    always_comb begin
        prefix_ok_s = 1'b1;
        for (int k = 1; k < N; k++) begin
            if (cdb_valid[k] && !cdb_valid[k-1]) begin
                prefix_ok_s = 1'b0;
            end else begin
                prefix_ok_s = prefix_ok_s;
            end
        end
    end

    a_slot_prefix: assert property (@(posedge clock) disable iff (reset) prefix_ok_s);
    a_ptr_range:   assert property (@(posedge clock) disable iff (reset) (int'(rr_ptr) < NUM_REQ));

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter (NUM_REQ=8, N=3): reset, single result, oversubscription,
// wrap-around, back-to-back refill, flush and async reset; bypass scenario when CDB_BYPASS_EN is defined.
module tb_cdb_arbiter;

    logic         clock;
    logic         reset;
    logic         mispredict;
    logic [7:0]   fu_valid;
    logic [47:0]  fu_tag;
    logic [39:0]  fu_rob_idx;
    logic [255:0] fu_data;
    logic [7:0]   fu_ready;
    logic [2:0]   cdb_valid;
    logic [17:0]  cdb_tag;
    logic [14:0]  cdb_rob_idx;
    logic [95:0]  cdb_data;

    int n_cmp;
    int n_fail;

    cdb_arbiter #(
        .NUM_REQ(8), .N(3), .PHYS_TAG_W(6), .ROB_IDX_W(5), .DATA_W(32)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .mispredict  (mispredict),
        .fu_valid    (fu_valid),
        .fu_tag      (fu_tag),
        .fu_rob_idx  (fu_rob_idx),
        .fu_data     (fu_data),
        .fu_ready    (fu_ready),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_rob_idx (cdb_rob_idx),
        .cdb_data    (cdb_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        mispredict = 1'b0;
        fu_valid   = 8'h00;
        #2;
        reset      = 1'b0;
    endtask

    task automatic set_fu(input int i, input logic [5:0] t, input logic [4:0] r, input logic [31:0] d);
        fu_valid[i]          = 1'b1;
        fu_tag[i*6 +: 6]     = t;
        fu_rob_idx[i*5 +: 5] = r;
        fu_data[i*32 +: 32]  = d;
    endtask

    task automatic load_0_to_4();
        for (int i = 0; i < 5; i++) begin
            set_fu(i, 6'(32 + i), 5'(8 + i), 32'h1000 + 32'(i));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        n_cmp++; if (cdb_valid !== 3'b000) begin n_fail++; $display("FAIL reset_cdb_valid got=%b exp=%b", cdb_valid, 3'b000); end
        n_cmp++; if (cdb_tag !== 18'h0) begin n_fail++; $display("FAIL reset_cdb_tag got=%h exp=0", cdb_tag); end
        n_cmp++; if (cdb_rob_idx !== 15'h0) begin n_fail++; $display("FAIL reset_cdb_rob got=%h exp=0", cdb_rob_idx); end
        n_cmp++; if (cdb_data !== 96'h0) begin n_fail++; $display("FAIL reset_cdb_data got=%h exp=0", cdb_data); end
        n_cmp++; if (fu_ready !== 8'hFF) begin n_fail++; $display("FAIL reset_fu_ready got=%h exp=ff", fu_ready); end
        n_cmp++; if (dut.rr_ptr_r !== 3'd0) begin n_fail++; $display("FAIL reset_rr_ptr got=%0d exp=0", dut.rr_ptr_r); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        set_fu(2, 6'h11, 5'd4, 32'hDEADBEEF);
        tick();
        fu_valid = 8'h00;
        n_cmp++; if (cdb_valid !== 3'b000) begin n_fail++; $display("FAIL single_e0_valid got=%b exp=000", cdb_valid); end
        n_cmp++; if (fu_ready !== 8'hFF) begin n_fail++; $display("FAIL single_e0_ready got=%h exp=ff", fu_ready); end
        tick();
        n_cmp++; if (cdb_valid !== 3'b001) begin n_fail++; $display("FAIL single_e1_valid got=%b exp=001", cdb_valid); end
        n_cmp++; if (cdb_tag[5:0] !== 6'h11) begin n_fail++; $display("FAIL single_e1_tag got=%h exp=11", cdb_tag[5:0]); end
        n_cmp++; if (cdb_rob_idx[4:0] !== 5'd4) begin n_fail++; $display("FAIL single_e1_rob got=%0d exp=4", cdb_rob_idx[4:0]); end
        n_cmp++; if (cdb_data[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_e1_data got=%h exp=deadbeef", cdb_data[31:0]); end
        n_cmp++; if (cdb_tag[17:6] !== 12'h0) begin n_fail++; $display("FAIL single_e1_unused_tag got=%h exp=0", cdb_tag[17:6]); end
        n_cmp++; if (dut.rr_ptr_r !== 3'd3) begin n_fail++; $display("FAIL single_e1_rr got=%0d exp=3", dut.rr_ptr_r); end
        tick();
        n_cmp++; if (cdb_valid !== 3'b000) begin n_fail++; $display("FAIL single_e2_valid got=%b exp=000", cdb_valid); end
    endtask

    task automatic test_oversub();
        do_reset();
        load_0_to_4();
        tick();
        fu_valid = 8'h00;
        n_cmp++; if (fu_ready !== 8'hE7) begin n_fail++; $display("FAIL oversub_ready got=%h exp=e7", fu_ready); end
        tick();
        n_cmp++; if (cdb_valid !== 3'b111) begin n_fail++; $display("FAIL oversub_c1_valid got=%b exp=111", cdb_valid); end
        n_cmp++; if (cdb_tag !== {6'd34, 6'd33, 6'd32}) begin n_fail++; $display("FAIL oversub_c1_tags got=%h exp=%h", cdb_tag, {6'd34, 6'd33, 6'd32}); end
        n_cmp++; if (cdb_data !== {32'h1002, 32'h1001, 32'h1000}) begin n_fail++; $display("FAIL oversub_c1_data got=%h exp=%h", cdb_data, {32'h1002, 32'h1001, 32'h1000}); end
        n_cmp++; if (dut.rr_ptr_r !== 3'd3) begin n_fail++; $display("FAIL oversub_c1_rr got=%0d exp=3", dut.rr_ptr_r); end
        n_cmp++; if (fu_ready !== 8'hFF) begin n_fail++; $display("FAIL oversub_c1_ready got=%h exp=ff", fu_ready); end
        tick();
        n_cmp++; if (cdb_valid !== 3'b011) begin n_fail++; $display("FAIL oversub_c2_valid got=%b exp=011", cdb_valid); end
        n_cmp++; if (cdb_rob_idx !== {5'd0, 5'd12, 5'd11}) begin n_fail++; $display("FAIL oversub_c2_rob got=%h exp=%h", cdb_rob_idx, {5'd0, 5'd12, 5'd11}); end
        n_cmp++; if (dut.rr_ptr_r !== 3'd5) begin n_fail++; $display("FAIL oversub_c2_rr got=%0d exp=5", dut.rr_ptr_r); end
    endtask

    task automatic test_wrap();
        do_reset();
        set_fu(5, 6'h35, 5'd5, 32'h55);
        tick();
        fu_valid = 8'h00;
        tick();
        n_cmp++; if (dut.rr_ptr_r !== 3'd6) begin n_fail++; $display("FAIL wrap_setup_rr got=%0d exp=6", dut.rr_ptr_r); end
        set_fu(7, 6'h37, 5'd17, 32'h77);
        set_fu(0, 6'h30, 5'd10, 32'h00);
        set_fu(1, 6'h31, 5'd11, 32'h11);
        set_fu(5, 6'h25, 5'd15, 32'h5A);
        tick();
        fu_valid = 8'h00;
        n_cmp++; if (fu_ready !== 8'hDF) begin n_fail++; $display("FAIL wrap_ready got=%h exp=df", fu_ready); end
        tick();
        n_cmp++; if (cdb_valid !== 3'b111) begin n_fail++; $display("FAIL wrap_c1_valid got=%b exp=111", cdb_valid); end
        n_cmp++; if (cdb_tag !== {6'h31, 6'h30, 6'h37}) begin n_fail++; $display("FAIL wrap_c1_tags got=%h exp=%h", cdb_tag, {6'h31, 6'h30, 6'h37}); end
        n_cmp++; if (dut.rr_ptr_r !== 3'd2) begin n_fail++; $display("FAIL wrap_c1_rr got=%0d exp=2", dut.rr_ptr_r); end
        tick();
        n_cmp++; if (cdb_valid !== 3'b001) begin n_fail++; $display("FAIL wrap_c2_valid got=%b exp=001", cdb_valid); end
        n_cmp++; if (cdb_data[31:0] !== 32'h5A) begin n_fail++; $display("FAIL wrap_c2_data got=%h exp=5a", cdb_data[31:0]); end
        n_cmp++; if (dut.rr_ptr_r !== 3'd6) begin n_fail++; $display("FAIL wrap_c2_rr got=%0d exp=6", dut.rr_ptr_r); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_fu(1, 6'h41, 5'd1, 32'd1);
        tick();
        set_fu(1, 6'h41, 5'd1, 32'd2);
        n_cmp++; if (fu_ready[1] !== 1'b1) begin n_fail++; $display("FAIL b2b_ready0 got=%b exp=1", fu_ready[1]); end
        tick();
        n_cmp++; if (cdb_valid !== 3'b001) begin n_fail++; $display("FAIL b2b_c1_valid got=%b exp=001", cdb_valid); end
        n_cmp++; if (cdb_data[31:0] !== 32'd1) begin n_fail++; $display("FAIL b2b_c1_data got=%0d exp=1", cdb_data[31:0]); end
        set_fu(1, 6'h41, 5'd1, 32'd3);
        n_cmp++; if (fu_ready[1] !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1 got=%b exp=1", fu_ready[1]); end
        tick();
        fu_valid = 8'h00;
        n_cmp++; if (cdb_data[31:0] !== 32'd2) begin n_fail++; $display("FAIL b2b_c2_data got=%0d exp=2", cdb_data[31:0]); end
        tick();
        n_cmp++; if (cdb_valid !== 3'b001) begin n_fail++; $display("FAIL b2b_c3_valid got=%b exp=001", cdb_valid); end
        n_cmp++; if (cdb_data[31:0] !== 32'd3) begin n_fail++; $display("FAIL b2b_c3_data got=%0d exp=3", cdb_data[31:0]); end
        tick();
        n_cmp++; if (cdb_valid !== 3'b000) begin n_fail++; $display("FAIL b2b_c4_valid got=%b exp=000", cdb_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        load_0_to_4();
        tick();
        fu_valid = 8'h00;
        tick();
        mispredict = 1'b1;
        set_fu(6, 6'h36, 5'd6, 32'h66);
        n_cmp++; if (fu_ready !== 8'hFF) begin n_fail++; $display("FAIL flush_ready_during got=%h exp=ff", fu_ready); end
        tick();
        mispredict = 1'b0;
        fu_valid   = 8'h00;
        n_cmp++; if (cdb_valid !== 3'b000) begin n_fail++; $display("FAIL flush_valid got=%b exp=000", cdb_valid); end
        n_cmp++; if (cdb_data !== 96'h0) begin n_fail++; $display("FAIL flush_data got=%h exp=0", cdb_data); end
        n_cmp++; if (dut.rr_ptr_r !== 3'd3) begin n_fail++; $display("FAIL flush_rr got=%0d exp=3", dut.rr_ptr_r); end
        n_cmp++; if (fu_ready !== 8'hFF) begin n_fail++; $display("FAIL flush_ready_after got=%h exp=ff", fu_ready); end
        tick();
        n_cmp++; if (cdb_valid !== 3'b000) begin n_fail++; $display("FAIL flush_drained got=%b exp=000", cdb_valid); end
    endtask

    task automatic test_async_reset();
        do_reset();
        load_0_to_4();
        tick();
        fu_valid = 8'h00;
        tick();
        n_cmp++; if (cdb_valid !== 3'b111) begin n_fail++; $display("FAIL areset_pre_valid got=%b exp=111", cdb_valid); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (cdb_valid !== 3'b000) begin n_fail++; $display("FAIL areset_valid got=%b exp=000", cdb_valid); end
        n_cmp++; if (cdb_tag !== 18'h0) begin n_fail++; $display("FAIL areset_tag got=%h exp=0", cdb_tag); end
        n_cmp++; if (fu_ready !== 8'hFF) begin n_fail++; $display("FAIL areset_ready got=%h exp=ff", fu_ready); end
        reset = 1'b0;
        tick();
        n_cmp++; if (cdb_valid !== 3'b000) begin n_fail++; $display("FAIL areset_lost got=%b exp=000", cdb_valid); end
    endtask

    task automatic test_bypass();
        do_reset();
        set_fu(3, 6'h33, 5'd3, 32'hCAFE);
        n_cmp++; if (fu_ready[3] !== 1'b1) begin n_fail++; $display("FAIL bypass_ready got=%b exp=1", fu_ready[3]); end
        tick();
        fu_valid = 8'h00;
        n_cmp++; if (cdb_valid !== 3'b001) begin n_fail++; $display("FAIL bypass_valid got=%b exp=001", cdb_valid); end
        n_cmp++; if (cdb_tag[5:0] !== 6'h33) begin n_fail++; $display("FAIL bypass_tag got=%h exp=33", cdb_tag[5:0]); end
        n_cmp++; if (cdb_data[31:0] !== 32'hCAFE) begin n_fail++; $display("FAIL bypass_data got=%h exp=cafe", cdb_data[31:0]); end
        tick();
        n_cmp++; if (cdb_valid !== 3'b000) begin n_fail++; $display("FAIL bypass_no_repeat got=%b exp=000", cdb_valid); end
    endtask

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        reset      = 1'b1;
        mispredict = 1'b0;
        fu_valid   = 8'h00;
        fu_tag     = '0;
        fu_rob_idx = '0;
        fu_data    = '0;
        test_reset();
`ifdef CDB_BYPASS_EN
        test_bypass();
`else
        test_single();
        test_oversub();
        test_wrap();
        test_back_to_back();
        test_flush();
        test_async_reset();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Complete-side counterpart of the execute stage: accepts finished results from every functional unit over per-FU valid/ready handshakes, buffers one result per FU, and grants up to `N` of them per cycle onto the registered common data bus (CDB). The CDB output drives PRF writeback, RS/map-table wakeup and ROB completion. Backpressure via `fu_ready` stalls FUs that lose arbitration; `mispredict` flushes all in-flight results.

## Interface
- `NUM_REQ`, default 8: number of FU result sources (ALU+MULT+BRANCH+ADDR+MEM); must be ≥ `N`.
- `N`, default 3: CDB width (results broadcast per cycle).
- `PHYS_TAG_W`, default 6: physical tag width.
- `ROB_IDX_W`, default 5: ROB index width.
- `DATA_W`, default 32: result data width.
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `mispredict`  in  1  flush all buffered and outgoing results.
- `fu_valid`  in  NUM_REQ  FU i presents a result.
- `fu_tag`  in  NUM_REQ×PHYS_TAG_W  destination physical tag per FU.
- `fu_rob_idx`  in  NUM_REQ×ROB_IDX_W  ROB index per FU.
- `fu_data`  in  NUM_REQ×DATA_W  result value per FU.
- `fu_ready`  out  NUM_REQ  FU i's result is accepted this edge if `fu_valid[i]`.
- `cdb_valid`  out  N  CDB slot k carries a result.
- `cdb_tag`  out  N×PHYS_TAG_W  broadcast tag per slot.
- `cdb_rob_idx`  out  N×ROB_IDX_W  ROB index per slot.
- `cdb_data`  out  N×DATA_W  value per slot (PRF write data).

## Operation
- State: per-FU buffer `buf_valid[i]`, `buf_tag/rob/data[i]`; round-robin pointer `rr_ptr` (0..NUM_REQ-1); registered CDB outputs.
- Candidates: FU i is a candidate iff `buf_valid[i]` (plus bypass candidates, see Configuration).
- Grant: scan i = rr_ptr, rr_ptr+1, … mod NUM_REQ; first ≤N candidates granted, assigned to CDB slots 0,1,… in scan order. Unused slots get `cdb_valid`=0 (tag/rob/data don't-care, hold 0).
- `rr_ptr` next = (last granted index + 1) mod NUM_REQ; unchanged if nothing granted.
- `fu_ready[i]` = !buf_valid[i] || grant[i] (combinational). Handshake: transfer when `fu_valid[i] && fu_ready[i]` at an edge; FU must hold valid/payload stable until transfer; `fu_valid` must not depend on `fu_ready`.
- Granted buffer entry cleared at edge unless refilled by a simultaneous new transfer (refill wins; `buf_valid` stays 1 with new payload).
- Flush: `mispredict`=1 at an edge → all `buf_valid`←0, all `cdb_valid`←0, same-cycle transfers discarded; `rr_ptr` held. `fu_ready` = all 1s while `mispredict` is high.
- No ordering between FUs; per-FU order preserved (single buffer).

## Timing
- Reset (async): `buf_valid`=0, `rr_ptr`=0, `cdb_valid`=0, `cdb_tag`/`cdb_rob_idx`/`cdb_data`=0; `fu_ready`=all 1s.
- Latency without bypass: transfer at edge E0 → earliest `cdb_valid` after edge E1 (2 cycles fu_valid→CDB visible).
- Throughput: ≤N results/cycle; each FU sustains 1 result/cycle while continuously granted.
- Reset asserted mid-operation: all state cleared immediately, buffered results lost.
- Fairness: a buffered result waits at most ⌈NUM_REQ/N⌉ grant cycles.

## Configuration
- `CDB_BYPASS_EN` defined: FU i with `!buf_valid[i] && fu_valid[i]` is also a candidate using its input payload; if granted it goes straight to the CDB registers at E0 (1-cycle latency) and is not written to the buffer. `fu_ready` may then depend combinationally on `fu_valid`.
- Undefined: only buffered entries are candidates; `fu_ready[i]` depends only on state; 2-cycle latency.

## Test plan (NUM_REQ=8, N=3, no bypass unless stated)
- Single result: FU2 valid, tag 0x11, rob 4, data 0xDEADBEEF at E0 → after E1 `cdb_valid`=3'b001, slot0 = {0x11,4,0xDEADBEEF}; after E2 `cdb_valid`=0.
- Oversubscription: FUs 0–4 buffered, rr_ptr=0 → cycle 1 slots = FU0,1,2, rr_ptr=3, `fu_ready[3]`=`fu_ready[4]`=0; next cycle slots = FU3,4, rr_ptr=5.
- Wrap-around: rr_ptr=6, FUs 7,0,1,5 buffered → grants FU7,0,1 in slots 0–2, rr_ptr=2; FU5 granted next cycle.
- Back-to-back refill: FU1 valid every cycle with data 1,2,3 → CDB shows 1,2,3 on consecutive cycles, `fu_ready[1]` stays 1.
- Flush: FUs 0–4 buffered, `mispredict` high one edge → after edge `cdb_valid`=0, all buffers empty, rr_ptr unchanged; async reset mid-stream → all outputs 0 immediately.
- `CDB_BYPASS_EN`: FU3 valid into empty buffer at E0 → `cdb_valid[0]`=1 right after E0 with FU3 payload.
